// File: rtl/marie_pkg.sv
// Shared definitions for the MARIE-style datapath sequencer.
// Holds opcode constants, the sequencer state encoding and the datapath
// select codes understood by the downstream datapath block.
package marie_pkg;

    // Instruction opcodes, taken from instruction bits [7:6]
    localparam logic [1:0] OP_MOVE   = 2'b00;
    localparam logic [1:0] OP_MOVEIN = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;
    localparam logic [1:0] OP_HALT   = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WAITIN = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Datapath destination codes
    localparam logic [2:0] DST_ACC  = 3'd1;
    localparam logic [2:0] DST_BREG = 3'd2;
    localparam logic [2:0] DST_OUT  = 3'd4;

    // Datapath source codes
    localparam logic [2:0] SRC_ACC  = 3'd1;
    localparam logic [2:0] SRC_BREG = 3'd2;
    localparam logic [2:0] SRC_IN   = 3'd3;

endpackage

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Fetch/decode/execute sequencer that runs a program from an external
// synchronous instruction memory and drives the datapath select/enable lines.
// Also provides a one-word PortIN handshake (in_valid / in_ack).
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   run        - 1 = may leave FETCH, 0 = pause in FETCH
//   imem_addr  - instruction address (the PC)
//   imem_data  - instruction word, valid the cycle after imem_addr
//   in_valid   - PortIN holds new data
//   in_ack     - one-cycle pulse when PortIN data is consumed
//   seldst     - datapath destination select
//   selsrc     - datapath source select
//   dsten      - datapath destination enable
//   srcen      - datapath source enable
//   halted     - high while in HALT
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | present PC on imem_addr, wait for run
// DECODE  | latch instruction, advance PC (or load jump target)
// EXEC    | MOVE cycle, selects and enables driven
// WAITIN  | MOVEIN: idle until in_valid, then one consume cycle with in_ack
// HALT    | enables off, halted high, only rst leaves
module datapath_sequencer
    import marie_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              in_valid,
    output logic              in_ack,
    output logic [SEL_W-1:0]  seldst,
    output logic [SEL_W-1:0]  selsrc,
    output logic              dsten,
    output logic              srcen,
    output logic              halted
);

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [7:0]         ir;

    logic [1:0]         op_d;
    logic [2:0]         dst_d;
    logic [2:0]         src_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jump_target;

    assign op_d        = imem_data[7:6];
    assign dst_d       = imem_data[5:3];
    assign src_d       = imem_data[2:0];
    assign pc_inc      = pc + ADDR_W'(1);
    assign jump_target = ADDR_W'(imem_data[5:0]);
    assign imem_addr   = pc;

    // Outputs are registered against the state being entered, so each value
    // is visible during the cycle the FSM spends in that state. The MOVEIN
    // consume cycle is decided from in_valid at the edge that enters it,
    // which keeps a MOVEIN with data already present at three cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= '0;
            seldst <= '0;
            selsrc <= '0;
            dsten  <= 1'b0;
            srcen  <= 1'b0;
            in_ack <= 1'b0;
            halted <= 1'b0;
        end else begin
            seldst <= '0;
            selsrc <= '0;
            dsten  <= 1'b0;
            srcen  <= 1'b0;
            in_ack <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (run) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir <= imem_data;
                    pc <= pc_inc;
                    case (op_d)
                        OP_MOVE: begin
                            state  <= ST_EXEC;
                            seldst <= SEL_W'(dst_d);
                            selsrc <= SEL_W'(src_d);
                            dsten  <= |dst_d;
                            srcen  <= |dst_d;
                        end
                        OP_MOVEIN: begin
                            state <= ST_WAITIN;
                            if (in_valid) begin
                                seldst <= SEL_W'(dst_d);
                                selsrc <= SEL_W'(SRC_IN);
                                dsten  <= |dst_d;
                                srcen  <= |dst_d;
                                in_ack <= 1'b1;
                            end
                        end
                        OP_JUMP: begin
                            state <= ST_FETCH;
                            pc    <= jump_target;
                        end
                        default: begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                end
                ST_WAITIN: begin
                    // in_ack high means this was the consume cycle
                    if (in_ack) begin
                        state <= ST_FETCH;
                    end else if (in_valid) begin
                        seldst <= SEL_W'(ir[5:3]);
                        selsrc <= SEL_W'(SRC_IN);
                        dsten  <= |ir[5:3];
                        srcen  <= |ir[5:3];
                        in_ack <= 1'b1;
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: behavioural ROM and datapath, an
// instruction-level trace model, directed programs and randomized programs.
module tb_datapath_sequencer;

    localparam int NMAX = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [5:0] imem_addr;
    logic [7:0] imem_data;
    logic       in_valid;
    logic       in_ack;
    logic [2:0] seldst;
    logic [2:0] selsrc;
    logic       dsten;
    logic       srcen;
    logic       halted;

    always #5 clk = ~clk;

    datapath_sequencer #(.ADDR_W(6), .SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .seldst    (seldst),
        .selsrc    (selsrc),
        .dsten     (dsten),
        .srcen     (srcen),
        .halted    (halted)
    );

    // Synchronous ROM
    logic [7:0] rom [0:63];
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Behavioural datapath
    logic [7:0] port_in, acc, breg, port_out, src_val;
    always_comb begin
        src_val = 8'h00;
        case (selsrc)
            3'd1: src_val = acc;
            3'd2: src_val = breg;
            3'd3: src_val = port_in;
            default: src_val = 8'h00;
        endcase
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 8'h00; breg <= 8'h00; port_out <= 8'h00;
        end else if (dsten && srcen) begin
            case (seldst)
                3'd1: acc <= src_val;
                3'd2: breg <= src_val;
                3'd4: port_out <= src_val;
                default: ;
            endcase
        end
    end

    int checks = 0;
    int failures = 0;

    bit          run_a [NMAX];
    bit          inv_a [NMAX];
    logic [15:0] exp_tr [NMAX];

    function automatic logic [15:0] pk(input logic [5:0] a, input logic [2:0] d,
                                       input logic [2:0] s, input logic e,
                                       input logic k, input logic h);
        return {a, d, s, e, e, k, h};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Instruction-level model: walk the program and lay down the expected
    // output vector of every cycle.
    task automatic build_expected(input int n);
        int t = 0;
        logic [5:0] pc = 6'd0;
        logic [5:0] pcn;
        logic [7:0] ins;
        logic en;
        while (t < n) begin
            while (t < n && !run_a[t]) begin exp_tr[t] = pk(pc, 0, 0, 0, 0, 0); t++; end
            if (t >= n) break;
            exp_tr[t] = pk(pc, 0, 0, 0, 0, 0); t++;
            if (t >= n) break;
            exp_tr[t] = pk(pc, 0, 0, 0, 0, 0);
            ins = rom[pc];
            pcn = pc + 6'd1;
            t++;
            en = (ins[5:3] != 3'd0);
            case (ins[7:6])
                2'b00: begin
                    if (t < n) exp_tr[t] = pk(pcn, ins[5:3], ins[2:0], en, 0, 0);
                    t++; pc = pcn;
                end
                2'b01: begin
                    while (t < n && !inv_a[t-1]) begin exp_tr[t] = pk(pcn, 0, 0, 0, 0, 0); t++; end
                    if (t < n) exp_tr[t] = pk(pcn, ins[5:3], 3'd3, en, 1, 0);
                    t++; pc = pcn;
                end
                2'b10: pc = ins[5:0];
                default: begin
                    while (t < n) begin exp_tr[t] = pk(pcn, 0, 0, 0, 0, 1); t++; end
                end
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {16'h0, imem_addr, seldst, selsrc, dsten, srcen, in_ack, halted}, 32'h0);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 64; i++) rom[i] = v;
    endtask

    task automatic fill_inputs(input bit r, input bit v);
        for (int i = 0; i < NMAX; i++) begin run_a[i] = r; inv_a[i] = v; end
    endtask

    task automatic run_trace(input int n, input string tag, input bit rnd_port);
        build_expected(n);
        for (int k = 0; k < n; k++) begin
            run = run_a[k];
            in_valid = inv_a[k];
            if (rnd_port) port_in = 8'($urandom);
            check($sformatf("%s_cyc%0d", tag, k),
                  {16'h0, imem_addr, seldst, selsrc, dsten, srcen, in_ack, halted},
                  {16'h0, exp_tr[k]});
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; in_valid = 1'b0; port_in = 8'h00;
        fill_rom(8'hC0);

        // MOVE ACC<-PortIN, MOVE PortOUT<-ACC, HALT
        fill_rom(8'hC0); rom[0] = 8'h0B; rom[1] = 8'h21; rom[2] = 8'hC0;
        fill_inputs(1, 0); port_in = 8'hFF;
        do_reset();
        run_trace(20, "prog1", 0);
        check("pin_move_exec", {16'h0, exp_tr[2]}, {16'h0, 16'b000001_001_011_1_1_0_0});
        check("pin_halt_decode", {16'h0, exp_tr[7]}, {16'h0, 16'b000010_000_000_0_0_0_0});
        check("pin_halted", {16'h0, exp_tr[8]}, {16'h0, 16'b000011_000_000_0_0_0_1});
        check("acc_ff", {24'h0, acc}, 32'hFF);
        check("portout_ff", {24'h0, port_out}, 32'hFF);

        // MOVEIN BREG waiting five cycles
        fill_rom(8'hC0); rom[0] = 8'h50;
        fill_inputs(1, 0);
        for (int i = 6; i < NMAX; i++) inv_a[i] = 1;
        port_in = 8'h0F;
        do_reset();
        run_trace(16, "movein", 0);
        check("pin_movein_wait", {16'h0, exp_tr[6]}, {16'h0, 16'b000001_000_000_0_0_0_0});
        check("pin_movein_ack", {16'h0, exp_tr[7]}, {16'h0, 16'b000001_010_011_1_1_1_0});
        check("breg_0f", {24'h0, breg}, 32'h0F);

        // Jump ping-pong between 0 and 63
        fill_rom(8'hC0); rom[0] = 8'hBF; rom[63] = 8'h80;
        fill_inputs(1, 0);
        do_reset();
        run_trace(20, "jump", 0);
        check("pin_jump_a0", {26'h0, exp_tr[0][15:10]}, 32'd0);
        check("pin_jump_a2", {26'h0, exp_tr[2][15:10]}, 32'd63);
        check("pin_jump_a4", {26'h0, exp_tr[4][15:10]}, 32'd0);

        // PC wrap: MOVE at 63
        fill_rom(8'hC0); rom[0] = 8'hBF; rom[63] = 8'h21;
        fill_inputs(1, 0);
        do_reset();
        run_trace(20, "wrap", 0);
        check("pin_wrap_exec", {16'h0, exp_tr[4]}, {16'h0, 16'b000000_100_001_1_1_0_0});

        // Two MOVEINs with in_valid held high, then a NOP MOVE
        fill_rom(8'hC0); rom[0] = 8'h48; rom[1] = 8'h48; rom[2] = 8'h03;
        fill_inputs(1, 1);
        do_reset();
        run_trace(16, "dblin", 1);
        check("pin_dbl_ack1", {31'h0, exp_tr[2][1]}, 32'd1);
        check("pin_dbl_ack2", {31'h0, exp_tr[5][1]}, 32'd1);
        check("pin_nop", {16'h0, exp_tr[8]}, {16'h0, 16'b000011_000_011_0_0_0_0});

        // Asynchronous reset during EXEC
        fill_rom(8'hC0); rom[0] = 8'h0B;
        fill_inputs(1, 0);
        do_reset();
        run = 1'b1;
        @(negedge clk); @(negedge clk);
        check("exec_en_before_rst", {30'h0, dsten, srcen}, 32'd3);
        #2 rst = 1'b1;
        #1 check("async_rst_en", {30'h0, dsten, srcen}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("after_rst_addr", {26'h0, imem_addr}, 32'd0);
        run_trace(10, "postrst", 0);

        // Randomized programs
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 64; i++) begin
                int r;
                r = $urandom_range(0, 15);
                rom[i][5:0] = 6'($urandom);
                rom[i][7:6] = (r < 7) ? 2'b00 : (r < 12) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            end
            for (int i = 0; i < NMAX; i++) begin
                run_a[i] = ($urandom_range(0, 3) != 0);
                inv_a[i] = ($urandom_range(0, 2) == 0);
            end
            do_reset();
            run_trace(300, $sformatf("rnd%0d", it), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
